// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Round-robin arbiter and sequencer in front of the shared single-port image
//   BRAM. Three requesters (0 = image loader, 1 = conv pixel fetch,
//   2 = result write-back) each issue single-word accesses. The arbiter
//   grants one at a time, drives the RAM command/address/data, returns read
//   data and pulses ack to the granted port. A read that never sees ram_ready
//   is aborted after RD_TIMEOUT cycles and completes with err.
//
//   Handshake: a port raises req[n] together with wr/addr/wdata and holds req
//   until it samples ack[n]; it drops req at that same edge. wr/addr/wdata are
//   captured at grant, so later changes are ignored. A req still high when the
//   arbiter is back in IDLE counts as a new request.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req, wr         per-port request and op (1 = write, 0 = read)
//   addr, wdata     per-port address / write data, port n at slice n
//   ack, err        one-cycle completion pulse / read-timeout flag
//   rdata           read data, valid with ack for a read
//   busy, gnt_id    access in progress / current or last granted port
//   ram_addr, ram_we, ram_din, ram_dout, ram_ready   BRAM side
//     ram_we codes: 00 null, 01 read, 10 write
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 19,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              wr,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              ack,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic [1:0]              gnt_id,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [1:0]              ram_we,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  input  logic                    ram_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(RD_TIMEOUT);

  state_t                  state_q, state_d;
  logic [2:0]              ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [1:0]              gnt_id_q, gnt_id_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [1:0]              ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_din_q, ram_din_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0]   addr_arr [3];
  logic [DATA_WIDTH-1:0]   wdata_arr [3];

  for (genvar n = 0; n < 3; n++) begin : g_unpack
    assign addr_arr[n]  = addr[n*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[n] = wdata[n*DATA_WIDTH +: DATA_WIDTH];
  end

  // (p + k) mod 3 for p in 0..2, k in 1..3
  function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Search order ptr+1, ptr+2, ptr: the last winner gets lowest priority.
  logic [1:0] cand0, cand1;
  logic       win_found;
  logic [1:0] win_id;

  always_comb begin
    cand0     = rr_add(ptr_q, 2'd1);
    cand1     = rr_add(ptr_q, 2'd2);
    win_found = 1'b1;
    win_id    = ptr_q;
    if (req[cand0])      win_id = cand0;
    else if (req[cand1]) win_id = cand1;
    else if (req[ptr_q]) win_id = ptr_q;
    else                 win_found = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 3'b000;
    err_d      = 1'b0;
    busy_d     = busy_q;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        ram_we_d = 2'b00;
        if (win_found) begin
          gnt_id_d   = win_id;
          ptr_d      = win_id;
          busy_d     = 1'b1;
          ram_addr_d = addr_arr[win_id];
          ram_din_d  = wdata_arr[win_id];
          if (wr[win_id]) begin
            ram_we_d = 2'b10;
            state_d  = S_WR;
          end else begin
            ram_we_d = 2'b01;
            cnt_d    = 8'd0;
            state_d  = S_RD;
          end
        end
      end
      S_WR: begin
        // The RAM accepts a write in a single cycle.
        ram_we_d = 2'b00;
        ack_d    = 3'b001 << gnt_id_q;
        state_d  = S_DONE;
      end
      S_RD: begin
        if (ram_ready) begin
          rdata_d  = ram_dout;
          ram_we_d = 2'b00;
          ack_d    = 3'b001 << gnt_id_q;
          state_d  = S_DONE;
        end else if (8'(cnt_q + 8'd1) == TIMEOUT_CNT) begin
          // Abort: complete with err, leave rdata untouched.
          ram_we_d = 2'b00;
          ack_d    = 3'b001 << gnt_id_q;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      S_DONE: begin
        // Extra cycle lets the requester drop req before re-arbitration.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= 3'b000;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      gnt_id_q   <= 2'd2;
      ptr_q      <= 2'd2;
      cnt_q      <= 8'd0;
      ram_we_q   <= 2'b00;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_id_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter. Inputs change 1 time unit after
// a rising edge; outputs are sampled at that same point, i.e. they show the
// values registered at the preceding edge ("cycle N" after grant edge 0).
module tb_bram_port_arbiter;
  localparam int DW = 24;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req, wr;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]    ack;
  logic          err;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [1:0]    gnt_id;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_ready;

  int tests  = 0;
  int failed = 0;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ready(ram_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 3'b000; ram_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic set_port(input int n, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    wr[n] = w;
    addr[n*AW +: AW] = a;
    wdata[n*DW +: DW] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests++; if (ack !== 3'b000) begin failed++; $display("FAIL reset_ack got %b exp 000", ack); end
    tests++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (ram_we !== 2'b00) begin failed++; $display("FAIL reset_ram_we got %b exp 00", ram_we); end
    tests++; if (ram_addr !== 19'h0) begin failed++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
    tests++; if (ram_din !== 24'h0) begin failed++; $display("FAIL reset_ram_din got %h exp 0", ram_din); end
    tests++; if (rdata !== 24'h0) begin failed++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    tests++; if (gnt_id !== 2'd2) begin failed++; $display("FAIL reset_gnt_id got %0d exp 2", gnt_id); end
  endtask

  task automatic test_write();
    set_port(0, 1'b1, 19'h40000, 24'hA1B2C3);
    req = 3'b001;
    tick(); // edge 0: grant
    tests++; if (ram_we !== 2'b10) begin failed++; $display("FAIL wr_cmd got %b exp 10", ram_we); end
    tests++; if (ram_addr !== 19'h40000) begin failed++; $display("FAIL wr_addr got %h exp 40000", ram_addr); end
    tests++; if (ram_din !== 24'hA1B2C3) begin failed++; $display("FAIL wr_din got %h exp a1b2c3", ram_din); end
    tests++; if (busy !== 1'b1 || gnt_id !== 2'd0 || ack !== 3'b000) begin
      failed++; $display("FAIL wr_grant got busy=%b gnt=%0d ack=%b exp 1 0 000", busy, gnt_id, ack); end
    tick();
    tests++; if (ack !== 3'b001) begin failed++; $display("FAIL wr_ack got %b exp 001", ack); end
    tests++; if (ram_we !== 2'b00) begin failed++; $display("FAIL wr_cmd_one_cycle got %b exp 00", ram_we); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL wr_busy_ack got %b exp 1", busy); end
    req = 3'b000;
    tick();
    tests++; if (busy !== 1'b0 || ack !== 3'b000) begin
      failed++; $display("FAIL wr_done got busy=%b ack=%b exp 0 000", busy, ack); end
  endtask

  task automatic test_read();
    int rd_cycles;
    rd_cycles = 0;
    set_port(1, 1'b0, 19'd512, 24'h0);
    req = 3'b010;
    tick(); // cycle 1
    tests++; if (ram_addr !== 19'd512 || gnt_id !== 2'd1) begin
      failed++; $display("FAIL rd_grant got addr=%h gnt=%0d exp 200 1", ram_addr, gnt_id); end
    if (ram_we == 2'b01) rd_cycles++;
    tick(); // cycle 2
    if (ram_we == 2'b01) rd_cycles++;
    tick(); // cycle 3: RAM answers
    if (ram_we == 2'b01) rd_cycles++;
    ram_ready = 1'b1; ram_dout = 24'h112233;
    tick(); // cycle 4
    if (ram_we == 2'b01) rd_cycles++;
    ram_ready = 1'b0; ram_dout = 24'h0;
    tests++; if (rd_cycles !== 3) begin failed++; $display("FAIL rd_cmd_cycles got %0d exp 3", rd_cycles); end
    tests++; if (ack !== 3'b010) begin failed++; $display("FAIL rd_ack got %b exp 010", ack); end
    tests++; if (rdata !== 24'h112233) begin failed++; $display("FAIL rd_data got %h exp 112233", rdata); end
    tests++; if (err !== 1'b0) begin failed++; $display("FAIL rd_err got %b exp 0", err); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_addr_hold();
    set_port(1, 1'b0, 19'h00100, 24'h0);
    req = 3'b010; // ptr=1 -> order 2,0,1 -> port 1
    tick(); tick();
    addr[1*AW +: AW] = 19'h7FFFF;
    wr[1] = 1'b1;
    tick();
    tests++; if (ram_addr !== 19'h00100 || ram_we !== 2'b01) begin
      failed++; $display("FAIL hold_addr got addr=%h we=%b exp 00100 01", ram_addr, ram_we); end
    tick();
    tests++; if (ram_addr !== 19'h00100) begin failed++; $display("FAIL hold_addr2 got %h exp 00100", ram_addr); end
    ram_ready = 1'b1; ram_dout = 24'h445566;
    tick();
    ram_ready = 1'b0;
    tests++; if (ack !== 3'b010 || rdata !== 24'h445566 || ram_addr !== 19'h00100) begin
      failed++; $display("FAIL hold_ack got ack=%b rdata=%h addr=%h exp 010 445566 00100", ack, rdata, ram_addr); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_timeout();
    int n, rd_cycles;
    n = 0; rd_cycles = 0;
    set_port(2, 1'b0, 19'h12345, 24'h0);
    req = 3'b100;
    tick();
    while (ack === 3'b000 && n < 40) begin
      if (ram_we == 2'b01) rd_cycles++;
      tick();
      n++;
    end
    tests++; if (rd_cycles !== 15) begin failed++; $display("FAIL to_cycles got %0d exp 15", rd_cycles); end
    tests++; if (ack !== 3'b100 || err !== 1'b1) begin
      failed++; $display("FAIL to_ack_err got ack=%b err=%b exp 100 1", ack, err); end
    tests++; if (ram_we !== 2'b00) begin failed++; $display("FAIL to_we got %b exp 00", ram_we); end
    tests++; if (rdata !== 24'h445566) begin failed++; $display("FAIL to_rdata got %h exp 445566", rdata); end
    req = 3'b000;
    tick();
    tests++; if (err !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL to_done got err=%b busy=%b exp 0 0", err, busy); end
  endtask

  task automatic test_reset_in_rd();
    set_port(0, 1'b0, 19'h00033, 24'h0);
    set_port(1, 1'b0, 19'h00044, 24'h0);
    req = 3'b010; // ptr=2 -> order 0,1,2 -> port 1
    tick(); tick();
    tests++; if (ram_we !== 2'b01 || gnt_id !== 2'd1) begin
      failed++; $display("FAIL rst_rd_pre got we=%b gnt=%0d exp 01 1", ram_we, gnt_id); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (ram_we !== 2'b00 || ack !== 3'b000 || busy !== 1'b0 || gnt_id !== 2'd2 || rdata !== 24'h0) begin
      failed++; $display("FAIL rst_rd got we=%b ack=%b busy=%b gnt=%0d rdata=%h exp 00 000 0 2 0",
                         ram_we, ack, busy, gnt_id, rdata); end
    req = 3'b011;
    tick();
    tests++; if (gnt_id !== 2'd0 || ram_addr !== 19'h00033) begin
      failed++; $display("FAIL rst_rd_regrant got gnt=%0d addr=%h exp 0 00033", gnt_id, ram_addr); end
    ram_ready = 1'b1; ram_dout = 24'h0;
    tick();
    ram_ready = 1'b0;
    req = 3'b000;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int n, exp_id;
    logic [2:0] exp_ack;
    apply_reset();
    set_port(0, 1'b1, 19'h1, 24'h1);
    set_port(1, 1'b1, 19'h2, 24'h2);
    set_port(2, 1'b1, 19'h3, 24'h3);
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      exp_id  = g % 3;
      exp_ack = 3'b001 << exp_id;
      n = 0;
      while (ack === 3'b000 && n < 20) begin
        tick();
        n++;
      end
      tests++; if (ack !== exp_ack || gnt_id !== 2'(exp_id)) begin
        failed++; $display("FAIL rr_grant_%0d got ack=%b gnt=%0d exp %b %0d", g, ack, gnt_id, exp_ack, exp_id); end
      req[exp_id] = 1'b0;
      tick();
      req[exp_id] = 1'b1;
    end
    req = 3'b000;
    tick(); tick(); tick(); tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; req = 3'b000; wr = 3'b000; addr = '0; wdata = '0;
    ram_dout = '0; ram_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_addr_hold();
    test_timeout();
    test_reset_in_rd();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
